// File: rtl/idct_transpose_buf.sv
// Ping-pong NxN transpose buffer between the row-pass and column-pass IDCT stages.
// Rows are written into one bank while the other bank is read out column by column (or row by row in bypass).
module idct_transpose_buf #(
    parameter int N = 4,
    parameter int W = 25
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sof,
    input  logic           in_mode,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sof,
    output logic [N*W-1:0] out_data,
    output logic           sof_err
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ZERO = CW'(0);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [W-1:0]  r_mem [2][N][N];
    logic [1:0]    r_full;
    logic [1:0]    r_mode;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [CW-1:0] r_row_cnt;
    logic [CW-1:0] r_col_cnt;
    logic          r_sof_err;

    logic          w_accept;
    logic          w_restart;
    logic [CW-1:0] w_row_idx;
    logic          w_wr_done;
    logic          w_sof_viol;
    logic          w_xfer;
    logic          w_rd_done;

    assign in_ready   = ~r_full[r_wr_bank];
    assign w_accept   = in_valid & in_ready;
    // A sof beat in mid-block drops the partial rows and restarts at row 0 of the same bank.
    assign w_restart  = w_accept & in_sof & (r_row_cnt != ZERO);
    assign w_row_idx  = w_restart ? ZERO : r_row_cnt;
    assign w_wr_done  = w_accept & ~w_restart & (r_row_cnt == LAST);
    assign w_sof_viol = w_accept & (in_sof ? (r_row_cnt != ZERO) : (r_row_cnt == ZERO));

    assign out_valid  = r_full[r_rd_bank];
    assign out_sof    = out_valid & (r_col_cnt == ZERO);
    assign w_xfer     = out_valid & out_ready;
    assign w_rd_done  = w_xfer & (r_col_cnt == LAST);
    assign sof_err    = r_sof_err;

    // Write-side bookkeeping: row counter, bank select, per-bank mode, sync error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_bank <= 1'b0;
            r_row_cnt <= ZERO;
            r_mode    <= 2'b11;
            r_sof_err <= 1'b0;
        end else begin
            r_sof_err <= w_sof_viol;
            if (w_accept) begin
                if (w_row_idx == ZERO) begin
                    r_mode[r_wr_bank] <= in_mode;
                end
                if (w_restart) begin
                    r_row_cnt <= ONE;
                end else if (w_wr_done) begin
                    r_row_cnt <= ZERO;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_row_cnt <= r_row_cnt + ONE;
                end
            end
        end
    end

    // Read-side bookkeeping: column counter and bank select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_bank <= 1'b0;
            r_col_cnt <= ZERO;
        end else if (w_xfer) begin
            if (w_rd_done) begin
                r_col_cnt <= ZERO;
                r_rd_bank <= ~r_rd_bank;
            end else begin
                r_col_cnt <= r_col_cnt + ONE;
            end
        end
    end

    // Full flags: set and clear never hit the same bank in one cycle, so both apply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_done && (r_wr_bank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_rd_done && (r_rd_bank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end else begin
                    r_full[b] <= r_full[b];
                end
            end
        end
    end

    // Sample storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < N; k++) begin
                r_mem[r_wr_bank][w_row_idx][k] <= in_data[k*W +: W];
            end
        end
    end

    // Output lane select: column col_cnt when transposing, row col_cnt in bypass.
    always_comb begin
        out_data = {(N*W){1'b0}};
        for (int k = 0; k < N; k++) begin
            if (r_mode[r_rd_bank]) begin
                out_data[k*W +: W] = r_mem[r_rd_bank][k][r_col_cnt];
            end else begin
                out_data[k*W +: W] = r_mem[r_rd_bank][r_col_cnt][k];
            end
        end
    end

endmodule
